// File: rtl/pipelined_onehot_decoder.sv
// pipelined_onehot_decoder: ADDR_W-bit address + enable to one-hot vector, valid/ready with 2-entry skid buffer
// Optional macro ZERO_REG_MASK_EN: address 0 decodes to an all-zero vector (hard-wired zero register).
module pipelined_onehot_decoder #(
    parameter int ADDR_W = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic                       in_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [(1 << ADDR_W)-1:0]   out_onehot,
    output logic [ADDR_W-1:0]          out_addr
);
    localparam int OUT_W = 1 << ADDR_W;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t              state, state_nxt;
    logic [OUT_W-1:0]    or_vec, sr_vec, dec;
    logic [ADDR_W-1:0]   or_addr, sr_addr;
    logic                acc, dlv, ld_or_in, ld_or_sr, ld_sr;

    assign in_ready   = (state != TWO) & ~reset;
    assign out_valid  = state != EMPTY;
    assign out_onehot = or_vec;
    assign out_addr   = or_addr;
    assign acc        = in_valid & in_ready;
    assign dlv        = out_valid & out_ready;

    // decode captured at accept time; optionally mask the zero register
    always_comb begin
        dec          = '0;
        dec[in_addr] = in_en;
`ifdef ZERO_REG_MASK_EN
        if (in_addr == '0) dec = '0;
`endif
    end

    // next state and register load selects from occupancy and handshakes
    always_comb begin
        state_nxt = state;
        ld_or_in  = 1'b0;
        ld_or_sr  = 1'b0;
        ld_sr     = 1'b0;
        case (state)
            EMPTY: begin
                ld_or_in  = acc;
                state_nxt = acc ? ONE : EMPTY;
            end
            ONE: begin
                ld_or_in  = acc & dlv;
                ld_sr     = acc & ~dlv;
                state_nxt = (acc & ~dlv) ? TWO : (~acc & dlv) ? EMPTY : ONE;
            end
            TWO: begin
                ld_or_sr  = dlv;
                state_nxt = dlv ? ONE : TWO;
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end

    // state and storage registers; the output vector is zeroed whenever nothing is held
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            or_vec  <= '0;
            or_addr <= '0;
            sr_vec  <= '0;
            sr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == EMPTY) or_vec <= '0;
            else if (ld_or_in) begin
                or_vec  <= dec;
                or_addr <= in_addr;
            end else if (ld_or_sr) begin
                or_vec  <= sr_vec;
                or_addr <= sr_addr;
            end
            if (ld_sr) begin
                sr_vec  <= dec;
                sr_addr <= in_addr;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_onehot_decoder.sv
// tb_pipelined_onehot_decoder: directed vector table on ADDR_W=3, random scoreboard run on ADDR_W=5
module tb_pipelined_onehot_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, flush, iv, ir, ie, ov, ordy;
    logic [2:0] ia, oa;
    logic [7:0] oh;

    logic        flush5, iv5, ir5, ie5, ov5, ordy5;
    logic [4:0]  ia5, oa5;
    logic [31:0] oh5;

    pipelined_onehot_decoder dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv), .in_ready(ir),
        .in_addr(ia), .in_en(ie), .out_valid(ov), .out_ready(ordy),
        .out_onehot(oh), .out_addr(oa)
    );

    pipelined_onehot_decoder #(.ADDR_W(5)) dut5 (
        .clk(clk), .reset(reset), .flush(flush5), .in_valid(iv5), .in_ready(ir5),
        .in_addr(ia5), .in_en(ie5), .out_valid(ov5), .out_ready(ordy5),
        .out_onehot(oh5), .out_addr(oa5)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] onehot_of(input int a, input logic en);
        logic masked;
`ifdef ZERO_REG_MASK_EN
        masked = (a == 0);
`else
        masked = 1'b0;
`endif
        return (en && !masked) ? (64'd1 << a) : 64'd0;
    endfunction

    typedef struct {
        logic       v;
        logic [2:0] a;
        logic       e;
        logic       r;
        logic       f;
        logic       ev;
        logic [7:0] eoh;
        logic [2:0] ea;
        logic       eir;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input int a, input logic e, input logic r, input logic f,
                                input logic ev, input int oa_i, input logic oe, input logic eir, input string tag);
        vec_t t;
        t.v = v; t.a = 3'(a); t.e = e; t.r = r; t.f = f;
        t.ev = ev; t.ea = 3'(oa_i); t.eoh = ev ? 8'(onehot_of(oa_i, oe)) : 8'h00; t.eir = eir; t.tag = tag;
        return t;
    endfunction

    task automatic apply(input vec_t t);
        iv = t.v; ia = t.a; ie = t.e; ordy = t.r; flush = t.f;
        @(posedge clk);
        #1;
        chk({t.tag, ".out_valid"}, 64'(ov), 64'(t.ev));
        chk({t.tag, ".out_onehot"}, 64'(oh), 64'(t.eoh));
        chk({t.tag, ".in_ready"}, 64'(ir), 64'(t.eir));
        if (t.ev) chk({t.tag, ".out_addr"}, 64'(oa), 64'(t.ea));
    endtask

    typedef struct {
        int   a;
        logic e;
    } beat_t;

    beat_t q[$];

    initial begin
        reset = 1'b1; flush = 1'b0; iv = 1'b0; ia = '0; ie = 1'b0; ordy = 1'b0;
        flush5 = 1'b0; iv5 = 1'b0; ia5 = '0; ie5 = 1'b0; ordy5 = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset.out_valid", 64'(ov), 64'd0);
            chk("reset.out_onehot", 64'(oh), 64'd0);
            chk("reset.out_addr", 64'(oa), 64'd0);
            chk("reset.in_ready", 64'(ir), 64'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_reset.in_ready", 64'(ir), 64'd1);
        chk("post_reset.out_valid", 64'(ov), 64'd0);

        for (int k = 0; k < 8; k++) vecs.push_back(mk(1, k, 1, 1, 0, 1, k, 1, 1, "stream"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, "stream_drain"));
        vecs.push_back(mk(1, 5, 1, 0, 0, 1, 5, 1, 1, "bp_acc1"));
        vecs.push_back(mk(1, 6, 1, 0, 0, 1, 5, 1, 0, "bp_acc2"));
        vecs.push_back(mk(1, 7, 1, 0, 0, 1, 5, 1, 0, "bp_full"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 6, 1, 1, "bp_dlv1"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, "bp_dlv2"));
        vecs.push_back(mk(1, 3, 0, 0, 0, 1, 3, 0, 1, "en0"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, "en0_dlv"));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1, 1, 1, "fl_acc1"));
        vecs.push_back(mk(1, 2, 1, 0, 0, 1, 1, 1, 0, "fl_acc2"));
        vecs.push_back(mk(1, 4, 1, 0, 1, 0, 0, 0, 1, "fl_two"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, "fl_nostale"));
        vecs.push_back(mk(1, 3, 1, 0, 0, 1, 3, 1, 1, "fl_one"));
        vecs.push_back(mk(1, 5, 1, 1, 1, 0, 0, 0, 1, "fl_drop_acc"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, "fl_drop_chk"));
        vecs.push_back(mk(1, 0, 1, 1, 0, 1, 0, 1, 1, "addr0"));
        vecs.push_back(mk(1, 7, 0, 1, 0, 1, 7, 0, 1, "en0_addr7"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, "tail"));
        foreach (vecs[i]) apply(vecs[i]);

        // reset mid-stream drops both held entries
        apply(mk(1, 2, 1, 0, 0, 1, 2, 1, 1, "mid_acc1"));
        apply(mk(1, 4, 1, 0, 0, 1, 2, 1, 0, "mid_acc2"));
        iv = 1'b0; ordy = 1'b1; reset = 1'b1;
        #1;
        chk("mid_reset.in_ready_comb", 64'(ir), 64'd0);
        @(posedge clk);
        #1;
        chk("mid_reset.out_valid", 64'(ov), 64'd0);
        chk("mid_reset.out_onehot", 64'(oh), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_reset_after.out_valid", 64'(ov), 64'd0);
        chk("mid_reset_after.in_ready", 64'(ir), 64'd1);

        // random run on the 5-bit instance against a FIFO reference
        for (int i = 0; i < 10000; i++) begin
            logic exp_ir, acc, dlv;
            beat_t b;
            exp_ir = q.size() < 2;
            chk("rnd.in_ready", 64'(ir5), 64'(exp_ir));
            chk("rnd.out_valid", 64'(ov5), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("rnd.out_onehot", 64'(oh5), onehot_of(q[0].a, q[0].e));
                chk("rnd.out_addr", 64'(oa5), 64'(q[0].a));
            end else chk("rnd.out_onehot_idle", 64'(oh5), 64'd0);
            iv5 = 1'($urandom);
            ia5 = 5'($urandom);
            ie5 = $urandom_range(0, 3) != 0;
            ordy5 = 1'($urandom);
            flush5 = $urandom_range(0, 63) == 0;
            acc = iv5 && exp_ir;
            dlv = (q.size() > 0) && ordy5;
            b.a = int'(ia5);
            b.e = ie5;
            @(posedge clk);
            #1;
            if (dlv) void'(q.pop_front());
            if (flush5) q.delete();
            else if (acc) q.push_back(b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
